// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver running on the system clock with a
// tick-enable baud generator, 2-of-3 majority sampling, optional parity and an output FIFO.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 651,
    parameter int OVS        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dvalid,
    input  logic                 dready,
    output logic [AW:0]          level,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int OW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic                 sync1;
    logic                 rxs;
    logic                 prev;
    logic                 tick;
    logic [CW-1:0]        div_cnt;
    logic [OW-1:0]        os;
    logic [BW-1:0]        bidx;
    logic [2:0]           smp;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 os_last;
    logic                 maj3;
    logic                 maj_stop;
    logic                 stop_now;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 wr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    always_comb begin
        tick     = (div_cnt == CW'(CLK_DIV - 1));
        os_last  = (os == OW'(OVS - 1));
        maj3     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
        // Stop is decided on the third-sample tick itself, so the live rxs stands in for smp[2].
        maj_stop = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
        stop_now = tick && (state == STOP) && (os == OW'(OVS / 2 + 1));
        push     = stop_now && maj_stop;
        pop      = dvalid && dready;
        full     = (level == (AW + 1)'(FIFO_DEPTH));
        wr       = push && (!full || pop);
        dvalid   = (level != '0);
        dout     = mem[rptr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            os         <= '0;
            prev       <= 1'b1;
            smp        <= '1;
            bidx       <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (tick) begin
                prev <= rxs;
                if (os == OW'(OVS / 2 - 1)) smp[0] <= rxs;
                if (os == OW'(OVS / 2))     smp[1] <= rxs;
                if (os == OW'(OVS / 2 + 1)) smp[2] <= rxs;
                case (state)
                    IDLE: begin
                        if (prev && !rxs) begin
                            os    <= '0;
                            state <= START;
                        end
                    end
                    START: begin
                        if (os_last) begin
                            os <= '0;
                            if (maj3) begin
                                state <= IDLE;
                            end else begin
                                state <= DATA;
                                bidx  <= '0;
                                perr  <= 1'b0;
                            end
                        end else begin
                            os <= os + 1'b1;
                        end
                    end
                    DATA: begin
                        if (os_last) begin
                            os          <= '0;
                            shreg[bidx] <= maj3;
                            if (bidx == BW'(DATA_BITS - 1))
                                state <= (PARITY != 0) ? PAR : STOP;
                            else
                                bidx <= bidx + 1'b1;
                        end else begin
                            os <= os + 1'b1;
                        end
                    end
                    PAR: begin
                        if (os_last) begin
                            os    <= '0;
                            perr  <= (^shreg) ^ maj3 ^ (PARITY == 1);
                            state <= STOP;
                        end else begin
                            os <= os + 1'b1;
                        end
                    end
                    STOP: begin
                        if (os == OW'(OVS / 2 + 1)) begin
                            os    <= '0;
                            state <= IDLE;
                            if (maj_stop)
                                parity_err <= perr;
                            else
                                frame_err <= 1'b1;
                        end else begin
                            os <= os + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr) begin
                mem[wptr] <= shreg;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            level <= level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an even-parity instance share the serial line;
// directed table vectors, timed corner sequences and a queue-based randomized model.
module tb_uart_rx_fifo;
    localparam int CLK_DIV = 4;
    localparam int OVS     = 16;
    localparam int DBITS   = 8;
    localparam int DEPTH   = 4;
    localparam int BP      = CLK_DIV * OVS;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rxd;
    logic       dready;
    logic [7:0] a_dout, b_dout;
    logic       a_dvalid, b_dvalid;
    logic [2:0] a_level, b_level;
    logic       a_fe, a_pe, a_ov, b_fe, b_pe, b_ov;

    int vec = 0;
    int errs = 0;
    int edges = 0;
    int fe_cnt[2] = '{0, 0};
    int pe_cnt[2] = '{0, 0};
    int ov_cnt[2] = '{0, 0};
    int dv_cycles = 0;
    int last_dout = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_DIV(CLK_DIV), .OVS(OVS), .DATA_BITS(DBITS), .PARITY(0), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rstn(rstn), .rxd(rxd), .dout(a_dout), .dvalid(a_dvalid), .dready(dready),
        .level(a_level), .frame_err(a_fe), .parity_err(a_pe), .overrun(a_ov));

    uart_rx_fifo #(.CLK_DIV(CLK_DIV), .OVS(OVS), .DATA_BITS(DBITS), .PARITY(2), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .rstn(rstn), .rxd(rxd), .dout(b_dout), .dvalid(b_dvalid), .dready(dready),
        .level(b_level), .frame_err(b_fe), .parity_err(b_pe), .overrun(b_ov));

    always @(posedge clk) begin
        if (!rstn) edges <= 0;
        else       edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (a_fe) fe_cnt[0]++;
        if (a_pe) pe_cnt[0]++;
        if (a_ov) ov_cnt[0]++;
        if (b_fe) fe_cnt[1]++;
        if (b_pe) pe_cnt[1]++;
        if (b_ov) ov_cnt[1]++;
        if (a_dvalid) begin
            dv_cycles++;
            last_dout = int'(a_dout);
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish (got running, expected finished)");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BP) @(negedge clk);
    endtask

    // Caller must be sitting on a falling clock edge.
    task automatic send_frame(input logic [7:0] data, input bit use_par, input logic pbit,
                              input logic stop, input int low_after);
        rxd = 1'b0;
        wait_bits(1);
        for (int i = 0; i < DBITS; i++) begin
            rxd = data[i];
            wait_bits(1);
        end
        if (use_par) begin
            rxd = pbit;
            wait_bits(1);
        end
        rxd = stop;
        wait_bits(1);
        if (low_after > 0) begin
            rxd = 1'b0;
            wait_bits(low_after);
        end
        rxd = 1'b1;
        wait_bits(2);
    endtask

    task automatic pop_check(input int inst, input int exp);
        check(inst == 0 ? "a_pop_dvalid" : "b_pop_dvalid", int'(inst == 0 ? a_dvalid : b_dvalid), 1);
        check(inst == 0 ? "a_pop_dout" : "b_pop_dout", int'(inst == 0 ? a_dout : b_dout), exp);
        dready = 1'b1;
        @(negedge clk);
        dready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        rxd  = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_dout"},   int'(a_dout), 0);
        check({tag, "_a_dvalid"}, int'(a_dvalid), 0);
        check({tag, "_a_level"},  int'(a_level), 0);
        check({tag, "_a_errs"},   int'({a_fe, a_pe, a_ov}), 0);
        check({tag, "_b_level"},  int'(b_level), 0);
        check({tag, "_b_errs"},   int'({b_fe, b_pe, b_ov}), 0);
    endtask

    task automatic run_random(input int inst, input int n);
        int q[$];
        logic [7:0] data;
        logic stop_ok, pbit;
        int fe0, pe0, ov0, exp_pe, exp_ov, k;
        for (int f = 0; f < n; f++) begin
            data    = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 4) != 0);
            pbit    = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 7)) @(negedge clk);
            fe0 = fe_cnt[inst];
            pe0 = pe_cnt[inst];
            ov0 = ov_cnt[inst];
            send_frame(data, inst == 1, pbit, stop_ok, 0);
            exp_pe = (stop_ok && inst == 1 && (($countones(data) + int'(pbit)) % 2 != 0)) ? 1 : 0;
            exp_ov = 0;
            if (stop_ok) begin
                if (q.size() < DEPTH) q.push_back(int'(data));
                else exp_ov = 1;
            end
            check("rnd_frame_err", fe_cnt[inst] - fe0, stop_ok ? 0 : 1);
            check("rnd_parity_err", pe_cnt[inst] - pe0, exp_pe);
            check("rnd_overrun", ov_cnt[inst] - ov0, exp_ov);
            check("rnd_level", int'(inst == 0 ? a_level : b_level), q.size());
            k = $urandom_range(0, q.size());
            for (int p = 0; p < k; p++) pop_check(inst, q.pop_front());
            check("rnd_level_after_pop", int'(inst == 0 ? a_level : b_level), q.size());
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_after;
        int         exp_fe;
        int         exp_ov;
        int         exp_level;
        bit         pop_after;
    } vec_t;

    vec_t tbl[7];
    int   fe0, pe0, ov0, k, dpush, guard;

    initial begin
        tbl[0] = '{8'h3C, 1'b0, 3, 1, 0, 0, 1'b0};
        tbl[1] = '{8'h11, 1'b1, 0, 0, 0, 1, 1'b1};
        tbl[2] = '{8'h01, 1'b1, 0, 0, 0, 1, 1'b0};
        tbl[3] = '{8'h02, 1'b1, 0, 0, 0, 2, 1'b0};
        tbl[4] = '{8'h03, 1'b1, 0, 0, 0, 3, 1'b0};
        tbl[5] = '{8'h04, 1'b1, 0, 0, 0, 4, 1'b0};
        tbl[6] = '{8'h05, 1'b1, 0, 0, 1, 4, 1'b0};

        rstn   = 1'b0;
        rxd    = 1'b1;
        dready = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        repeat (BP) @(negedge clk);

        // Single 8N1 frame with the consumer always ready.
        dready    = 1'b1;
        dv_cycles = 0;
        fe0 = fe_cnt[0]; pe0 = pe_cnt[0]; ov0 = ov_cnt[0];
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0);
        dready = 1'b0;
        check("a5_dvalid_cycles", dv_cycles, 1);
        check("a5_dout", last_dout, 8'hA5);
        check("a5_level", int'(a_level), 0);
        check("a5_errors", (fe_cnt[0] - fe0) + (pe_cnt[0] - pe0) + (ov_cnt[0] - ov0), 0);

        // Short low glitch must be rejected as a false start.
        fe0 = fe_cnt[0];
        rxd = 1'b0;
        repeat (3 * CLK_DIV) @(negedge clk);
        rxd = 1'b1;
        wait_bits(2);
        check("glitch_level", int'(a_level), 0);
        check("glitch_frame_err", fe_cnt[0] - fe0, 0);

        for (int i = 0; i < 7; i++) begin
            fe0 = fe_cnt[0]; pe0 = pe_cnt[0]; ov0 = ov_cnt[0];
            send_frame(tbl[i].data, 1'b0, 1'b0, tbl[i].stop, tbl[i].low_after);
            check($sformatf("tbl%0d_frame_err", i), fe_cnt[0] - fe0, tbl[i].exp_fe);
            check($sformatf("tbl%0d_parity_err", i), pe_cnt[0] - pe0, 0);
            check($sformatf("tbl%0d_overrun", i), ov_cnt[0] - ov0, tbl[i].exp_ov);
            check($sformatf("tbl%0d_level", i), int'(a_level), tbl[i].exp_level);
            if (tbl[i].pop_after) begin
                pop_check(0, int'(tbl[i].data));
                check($sformatf("tbl%0d_level_after_pop", i), int'(a_level), tbl[i].exp_level - 1);
            end
        end

        // Full FIFO: pop exactly on the push edge of the next frame so both happen together.
        k = edges + 2;
        while (k % CLK_DIV != CLK_DIV - 1) k++;
        dpush = k + CLK_DIV * (1 + OVS * (1 + DBITS) + OVS / 2 + 1);
        ov0 = ov_cnt[0];
        fork
            send_frame(8'h06, 1'b0, 1'b0, 1'b1, 0);
            begin
                guard = 0;
                while (edges < dpush && guard < 5000) begin
                    @(negedge clk);
                    guard++;
                end
                check("pushpop_level_before", int'(a_level), 4);
                check("pushpop_head_before", int'(a_dout), 8'h01);
                dready = 1'b1;
                @(negedge clk);
                dready = 1'b0;
                check("pushpop_level_after", int'(a_level), 4);
                check("pushpop_overrun", int'(a_ov), 0);
            end
        join
        check("pushpop_overrun_total", ov_cnt[0] - ov0, 0);
        pop_check(0, 8'h02);
        pop_check(0, 8'h03);
        pop_check(0, 8'h04);
        pop_check(0, 8'h06);
        check("drain_level", int'(a_level), 0);
        check("drain_dvalid", int'(a_dvalid), 0);

        run_random(0, 12);

        // Reset in the middle of the data bits abandons the frame silently.
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 0);
        while (a_level != 0) pop_check(0, int'(a_dout));
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 0);
        check("pre_reset_level", int'(a_level), 1);
        fe0 = fe_cnt[0]; pe0 = pe_cnt[0]; ov0 = ov_cnt[0];
        rxd = 1'b0;
        wait_bits(1);
        rxd = 1'b1;
        wait_bits(1);
        rxd = 1'b0;
        wait_bits(2);
        rstn = 1'b0;
        @(negedge clk);
        check_zero("midframe_reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rxd  = 1'b1;
        wait_bits(2);
        check("post_reset_level", int'(a_level), 0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0);
        check("post_reset_errors", (fe_cnt[0] - fe0) + (pe_cnt[0] - pe0) + (ov_cnt[0] - ov0), 0);
        check("post_reset_5a_level", int'(a_level), 1);
        pop_check(0, 8'h5A);

        // Even-parity instance.
        do_reset();
        fe0 = fe_cnt[1]; pe0 = pe_cnt[1];
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0);
        check("par_bad_pe", pe_cnt[1] - pe0, 1);
        check("par_bad_fe", fe_cnt[1] - fe0, 0);
        check("par_bad_level", int'(b_level), 1);
        check("par_bad_dout", int'(b_dout), 8'h07);
        pe0 = pe_cnt[1];
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 0);
        check("par_ok_pe", pe_cnt[1] - pe0, 0);
        check("par_ok_level", int'(b_level), 2);
        pop_check(1, 8'h07);
        pop_check(1, 8'h07);

        run_random(1, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a clock-enable baud generator, majority-vote oversampling, optional parity and an output FIFO with a valid/ready handshake. It runs entirely on the system clock. It replaces the divided-clock scheme that currently feeds the serial debug unit, where the divider output itself is used as a clock. Frame and parity errors and FIFO overrun are reported as one-cycle pulses.

## Interface
- CLK_DIV, 651: clk cycles per oversample tick (≥2); 100 MHz/651 ≈ 16×9600.
- OVS, 16: ticks per bit (≥4, even).
- DATA_BITS, 8: data bits per frame (5..9), LSB first.
- PARITY, 0: 0 none, 1 odd, 2 even.
- FIFO_DEPTH, 4: entries, power of 2 (≥2); AW = log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- rxd  in  1  serial line, idle high, asynchronous to clk
- dout  out  DATA_BITS  FIFO head entry
- dvalid  out  1  FIFO not empty
- dready  in  1  consumer accepts dout this cycle
- level  out  AW+1  FIFO occupancy, 0..FIFO_DEPTH
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- parity_err  out  1  one-cycle pulse: parity mismatch
- overrun  out  1  one-cycle pulse: frame dropped, FIFO full

## Operation
- rxd passes through a 2-FF synchroniser (rxs), initialised to 1.
- Tick counter runs 0..CLK_DIV-1 and wraps. tick is high in the cycle where count==CLK_DIV-1. It free-runs and is never reset by frame events.
- All FSM activity advances only on tick. os counts 0..OVS-1 within a bit. Samples are taken at os = OVS/2-1, OVS/2 and OVS/2+1; the bit value is the 2-of-3 majority.
- prev holds rxs from the previous tick; its reset value is 1.
- States:
  - IDLE: on a tick with prev==1 and rxs==0, set os=0 and go to START.
  - START: at os==OVS-1, majority 1 means false start, return to IDLE. Majority 0 means go to DATA with os=0 and bit index 0.
  - DATA: at os==OVS-1, shift the majority into the shift register at bit index. After DATA_BITS bits, go to PAR if PARITY≠0, else STOP.
  - PAR: at os==OVS-1, check parity. Odd parity requires an odd count of ones over data+parity; even parity requires an even count. Latch the mismatch flag, then go to STOP.
  - STOP: decided at os==OVS/2+1, immediately after the third sample, then return to IDLE. This allows resync to a following start bit.
- Stop majority 1: push the frame, and pulse parity_err if the mismatch flag is set. Frames with parity errors are still pushed.
- Stop majority 0: pulse frame_err and discard the frame; no parity_err pulse. IDLE needs prev==1 before arming again, so a break condition (held low) produces exactly one frame_err.
- FIFO:
  - pop = dvalid & dready.
  - A push while full with no pop in the same cycle is dropped and pulses overrun; contents are unchanged.
  - A push while full with a simultaneous pop is accepted; level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - There is no empty bypass.
- dout is undefined-but-stable when dvalid=0 and holds its value until a pop.

## Timing
- Reset: FSM IDLE, os=0, tick count 0, prev=1, synchroniser 1, FIFO empty; dout=0, dvalid=0, level=0, all error pulses 0. Reset asserted mid-frame abandons the frame with no pulses.
- rxd to rxs: 2 cycles.
- Push occurs on the clk edge ending the STOP-decision tick cycle. dvalid and level update in the following cycle. frame_err, parity_err and overrun are asserted in that same following cycle, for exactly one cycle.
- Pop: level decrements and the head advances on the edge where dvalid&dready is high.
- Bit period = CLK_DIV×OVS cycles. Tolerated baud mismatch is about ±(OVS/2-2)/(OVS×(DATA_BITS+2)); for defaults this is ≈±3.7 %.

## Test plan
- CLK_DIV=4, OVS=16, 8N1, frame 0xA5, dready=1 → dvalid for one cycle with dout=0xA5, about 4 cycles after the stop-bit centre; no error pulses.
- Low glitch of 3 ticks on an idle line → returns to IDLE from START; level stays 0; no pulses.
- Frame 0x3C with stop bit driven 0, then the line held low for 3 bit periods → exactly one frame_err; level 0. Next valid frame 0x11 → dout=0x11.
- PARITY=2, frame 0x07 with parity bit 0 (wrong) → parity_err pulse; 0x07 pushed; level=1.
- FIFO_DEPTH=4, dready=0, frames 0x01..0x05 → level reaches 4; one overrun pulse on the fifth frame. Draining yields 0x01, 0x02, 0x03, 0x04. With the FIFO full, push and pop in the same cycle keep level=4.
- rstn pulsed low mid-DATA of a frame → all outputs 0. The next full frame 0x5A is received correctly.
